// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared decode constants for the D-stage of the 5-stage MIPS
//                core: opcode/funct values, control-field encodings,
//                hazard-timing constants and the immediate-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Primary opcodes
    localparam logic [5:0] c_op_rtype  = 6'h00;
    localparam logic [5:0] c_op_regimm = 6'h01;
    localparam logic [5:0] c_op_j      = 6'h02;
    localparam logic [5:0] c_op_jal    = 6'h03;
    localparam logic [5:0] c_op_beq    = 6'h04;
    localparam logic [5:0] c_op_bne    = 6'h05;
    localparam logic [5:0] c_op_blez   = 6'h06;
    localparam logic [5:0] c_op_bgtz   = 6'h07;
    localparam logic [5:0] c_op_addi   = 6'h08;
    localparam logic [5:0] c_op_addiu  = 6'h09;
    localparam logic [5:0] c_op_slti   = 6'h0A;
    localparam logic [5:0] c_op_sltiu  = 6'h0B;
    localparam logic [5:0] c_op_andi   = 6'h0C;
    localparam logic [5:0] c_op_ori    = 6'h0D;
    localparam logic [5:0] c_op_xori   = 6'h0E;
    localparam logic [5:0] c_op_lui    = 6'h0F;
    localparam logic [5:0] c_op_lb     = 6'h20;
    localparam logic [5:0] c_op_lh     = 6'h21;
    localparam logic [5:0] c_op_lw     = 6'h23;
    localparam logic [5:0] c_op_lbu    = 6'h24;
    localparam logic [5:0] c_op_lhu    = 6'h25;
    localparam logic [5:0] c_op_sb     = 6'h28;
    localparam logic [5:0] c_op_sh     = 6'h29;
    localparam logic [5:0] c_op_sw     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] c_fn_sll   = 6'h00;
    localparam logic [5:0] c_fn_srl   = 6'h02;
    localparam logic [5:0] c_fn_sra   = 6'h03;
    localparam logic [5:0] c_fn_sllv  = 6'h04;
    localparam logic [5:0] c_fn_srlv  = 6'h06;
    localparam logic [5:0] c_fn_srav  = 6'h07;
    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_jalr  = 6'h09;
    localparam logic [5:0] c_fn_mfhi  = 6'h10;
    localparam logic [5:0] c_fn_mthi  = 6'h11;
    localparam logic [5:0] c_fn_mflo  = 6'h12;
    localparam logic [5:0] c_fn_mtlo  = 6'h13;
    localparam logic [5:0] c_fn_mult  = 6'h18;
    localparam logic [5:0] c_fn_multu = 6'h19;
    localparam logic [5:0] c_fn_div   = 6'h1A;
    localparam logic [5:0] c_fn_divu  = 6'h1B;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_subu  = 6'h23;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_xor   = 6'h26;
    localparam logic [5:0] c_fn_nor   = 6'h27;
    localparam logic [5:0] c_fn_slt   = 6'h2A;
    localparam logic [5:0] c_fn_sltu  = 6'h2B;

    // ALU operations (lui passes the pre-shifted B operand through)
    localparam logic [4:0] c_alu_add  = 5'd0;
    localparam logic [4:0] c_alu_sub  = 5'd1;
    localparam logic [4:0] c_alu_and  = 5'd2;
    localparam logic [4:0] c_alu_or   = 5'd3;
    localparam logic [4:0] c_alu_xor  = 5'd4;
    localparam logic [4:0] c_alu_nor  = 5'd5;
    localparam logic [4:0] c_alu_slt  = 5'd6;
    localparam logic [4:0] c_alu_sltu = 5'd7;
    localparam logic [4:0] c_alu_sll  = 5'd8;
    localparam logic [4:0] c_alu_srl  = 5'd9;
    localparam logic [4:0] c_alu_sra  = 5'd10;
    localparam logic [4:0] c_alu_sllv = 5'd11;
    localparam logic [4:0] c_alu_srlv = 5'd12;
    localparam logic [4:0] c_alu_srav = 5'd13;
    localparam logic [4:0] c_alu_lui  = 5'd14;

    localparam logic [1:0] c_npc_pc4 = 2'd0;
    localparam logic [1:0] c_npc_br  = 2'd1;
    localparam logic [1:0] c_npc_j   = 2'd2;
    localparam logic [1:0] c_npc_jr  = 2'd3;

    localparam logic [1:0] c_wsel_alu = 2'd0;
    localparam logic [1:0] c_wsel_mem = 2'd1;
    localparam logic [1:0] c_wsel_pc8 = 2'd2;
    localparam logic [1:0] c_wsel_mdu = 2'd3;

    localparam logic [1:0] c_st_none = 2'd0;
    localparam logic [1:0] c_st_sw   = 2'd1;
    localparam logic [1:0] c_st_sh   = 2'd2;
    localparam logic [1:0] c_st_sb   = 2'd3;

    localparam logic [2:0] c_ld_lw  = 3'd0;
    localparam logic [2:0] c_ld_lh  = 3'd1;
    localparam logic [2:0] c_ld_lhu = 3'd2;
    localparam logic [2:0] c_ld_lb  = 3'd3;
    localparam logic [2:0] c_ld_lbu = 3'd4;

    localparam logic [3:0] c_mdu_none  = 4'd0;
    localparam logic [3:0] c_mdu_mult  = 4'd1;
    localparam logic [3:0] c_mdu_multu = 4'd2;
    localparam logic [3:0] c_mdu_div   = 4'd3;
    localparam logic [3:0] c_mdu_divu  = 4'd4;
    localparam logic [3:0] c_mdu_mfhi  = 4'd5;
    localparam logic [3:0] c_mdu_mflo  = 4'd6;
    localparam logic [3:0] c_mdu_mthi  = 4'd7;
    localparam logic [3:0] c_mdu_mtlo  = 4'd8;

    // Stage distances from D: operand needed / result available
    localparam logic [1:0] c_tuse_d    = 2'd0;
    localparam logic [1:0] c_tuse_e    = 2'd1;
    localparam logic [1:0] c_tuse_m    = 2'd2;
    localparam logic [1:0] c_tuse_none = 2'd3;

    localparam logic [1:0] c_tnew_none = 2'd0;
    localparam logic [1:0] c_tnew_pc8  = 2'd1;
    localparam logic [1:0] c_tnew_alu  = 2'd2;
    localparam logic [1:0] c_tnew_mem  = 2'd3;

    // Instruction classes: every class shares one waddr/wsel/timing pattern
    typedef enum logic [3:0] {
        CLS_RI, CLS_RALU, CLS_SHAMT, CLS_IALU, CLS_LUI, CLS_LOAD, CLS_STORE,
        CLS_BR2, CLS_BR1, CLS_J, CLS_JAL, CLS_JR, CLS_JALR, CLS_MD, CLS_MF, CLS_MT
    } instr_cls_e;

    function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        if (op == c_op_andi || op == c_op_ori || op == c_op_xori)
            return {16'h0000, imm};
        else if (op == c_op_lui)
            return {imm, 16'h0000};
        else
            return {{16{imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_unit_branch_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cmp
//  Description : Signed branch comparator with its own condition decode.
//                is_br is 0 for anything that is not a recognised branch.
//  Ports       : op, rt_field (instruction fields), rs_val, rt_val (forwarded
//                operands), is_br (condition true)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp
    import decode_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rt_field,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        is_br
);

    logic w_rs_zero;
    logic w_rs_neg;

    assign w_rs_zero = (rs_val == 32'd0);
    assign w_rs_neg  = rs_val[31];

    always_comb begin
        is_br = 1'b0;
        case (op)
            c_op_beq:    is_br = (rs_val == rt_val);
            c_op_bne:    is_br = (rs_val != rt_val);
            c_op_blez:   is_br = w_rs_neg | w_rs_zero;
            c_op_bgtz:   is_br = ~w_rs_neg & ~w_rs_zero;
            // regimm selects bltz/bgez through the rt field
            c_op_regimm: begin
                if (rt_field == 5'd0)
                    is_br = w_rs_neg;
                else if (rt_field == 5'd1)
                    is_br = ~w_rs_neg;
            end
            default:     is_br = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_unit
//  Description : D-stage of the 5-stage MIPS core. Holds the decode
//                instruction register and decodes it into control and
//                hazard-timing fields, extends the immediate and evaluates
//                the branch condition on forwarded operands.
//  Ports       : clk, resetn (sync, active-low), en (IR load), clr (IR flush),
//                instr_in, rs_val, rt_val -> instr, ext_out, is_br, npc_sel,
//                alu_op, srcb_imm, wsel, waddr, load, store, ld_type, mdu_op,
//                tuse_rs, tuse_rt, tnew, ri
//  Config      : DECODE_MDU_EN - decode mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_unit
    import decode_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] instr_in,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] instr,
    output logic [31:0] ext_out,
    output logic        is_br,
    output logic [1:0]  npc_sel,
    output logic [4:0]  alu_op,
    output logic        srcb_imm,
    output logic [1:0]  wsel,
    output logic [4:0]  waddr,
    output logic        load,
    output logic [1:0]  store,
    output logic [2:0]  ld_type,
    output logic [3:0]  mdu_op,
    output logic [1:0]  tuse_rs,
    output logic [1:0]  tuse_rt,
    output logic [1:0]  tnew,
    output logic        ri
);

    logic [31:0] r_instr;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    instr_cls_e  w_cls;

    // Instruction register: reset and flush both load the nop, and win over en
    always_ff @(posedge clk) begin
        if (!resetn || clr)
            r_instr <= RESET_INSTR;
        else if (en)
            r_instr <= instr_in;
    end

    assign instr   = r_instr;
    assign w_op    = r_instr[31:26];
    assign w_rt    = r_instr[20:16];
    assign w_rd    = r_instr[15:11];
    assign w_funct = r_instr[5:0];
    assign ext_out = ext_imm(w_op, r_instr[15:0]);

    branch_cmp u_branch_cmp (
        .op       (w_op),
        .rt_field (w_rt),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .is_br    (is_br)
    );

    // Opcode/funct -> instruction class plus per-instruction operation codes
    always_comb begin
        w_cls   = CLS_RI;
        alu_op  = c_alu_add;
        ld_type = c_ld_lw;
        store   = c_st_none;
        mdu_op  = c_mdu_none;
        case (w_op)
            c_op_rtype: begin
                case (w_funct)
                    c_fn_add, c_fn_addu: begin w_cls = CLS_RALU;  alu_op = c_alu_add;  end
                    c_fn_sub, c_fn_subu: begin w_cls = CLS_RALU;  alu_op = c_alu_sub;  end
                    c_fn_and:            begin w_cls = CLS_RALU;  alu_op = c_alu_and;  end
                    c_fn_or:             begin w_cls = CLS_RALU;  alu_op = c_alu_or;   end
                    c_fn_xor:            begin w_cls = CLS_RALU;  alu_op = c_alu_xor;  end
                    c_fn_nor:            begin w_cls = CLS_RALU;  alu_op = c_alu_nor;  end
                    c_fn_slt:            begin w_cls = CLS_RALU;  alu_op = c_alu_slt;  end
                    c_fn_sltu:           begin w_cls = CLS_RALU;  alu_op = c_alu_sltu; end
                    c_fn_sllv:           begin w_cls = CLS_RALU;  alu_op = c_alu_sllv; end
                    c_fn_srlv:           begin w_cls = CLS_RALU;  alu_op = c_alu_srlv; end
                    c_fn_srav:           begin w_cls = CLS_RALU;  alu_op = c_alu_srav; end
                    c_fn_sll:            begin w_cls = CLS_SHAMT; alu_op = c_alu_sll;  end
                    c_fn_srl:            begin w_cls = CLS_SHAMT; alu_op = c_alu_srl;  end
                    c_fn_sra:            begin w_cls = CLS_SHAMT; alu_op = c_alu_sra;  end
                    c_fn_jr:             w_cls = CLS_JR;
                    c_fn_jalr:           w_cls = CLS_JALR;
`ifdef DECODE_MDU_EN
                    c_fn_mult:           begin w_cls = CLS_MD; mdu_op = c_mdu_mult;  end
                    c_fn_multu:          begin w_cls = CLS_MD; mdu_op = c_mdu_multu; end
                    c_fn_div:            begin w_cls = CLS_MD; mdu_op = c_mdu_div;   end
                    c_fn_divu:           begin w_cls = CLS_MD; mdu_op = c_mdu_divu;  end
                    c_fn_mfhi:           begin w_cls = CLS_MF; mdu_op = c_mdu_mfhi;  end
                    c_fn_mflo:           begin w_cls = CLS_MF; mdu_op = c_mdu_mflo;  end
                    c_fn_mthi:           begin w_cls = CLS_MT; mdu_op = c_mdu_mthi;  end
                    c_fn_mtlo:           begin w_cls = CLS_MT; mdu_op = c_mdu_mtlo;  end
`endif
                    default:             w_cls = CLS_RI;
                endcase
            end
            c_op_regimm: begin
                if (w_rt == 5'd0 || w_rt == 5'd1)
                    w_cls = CLS_BR1;
            end
            c_op_j:                 w_cls = CLS_J;
            c_op_jal:               w_cls = CLS_JAL;
            c_op_beq, c_op_bne:     w_cls = CLS_BR2;
            c_op_blez, c_op_bgtz:   w_cls = CLS_BR1;
            c_op_addi, c_op_addiu:  begin w_cls = CLS_IALU; alu_op = c_alu_add;  end
            c_op_slti:              begin w_cls = CLS_IALU; alu_op = c_alu_slt;  end
            c_op_sltiu:             begin w_cls = CLS_IALU; alu_op = c_alu_sltu; end
            c_op_andi:              begin w_cls = CLS_IALU; alu_op = c_alu_and;  end
            c_op_ori:               begin w_cls = CLS_IALU; alu_op = c_alu_or;   end
            c_op_xori:              begin w_cls = CLS_IALU; alu_op = c_alu_xor;  end
            c_op_lui:               begin w_cls = CLS_LUI;  alu_op = c_alu_lui;  end
            c_op_lw:                begin w_cls = CLS_LOAD; ld_type = c_ld_lw;  end
            c_op_lh:                begin w_cls = CLS_LOAD; ld_type = c_ld_lh;  end
            c_op_lhu:               begin w_cls = CLS_LOAD; ld_type = c_ld_lhu; end
            c_op_lb:                begin w_cls = CLS_LOAD; ld_type = c_ld_lb;  end
            c_op_lbu:               begin w_cls = CLS_LOAD; ld_type = c_ld_lbu; end
            c_op_sw:                begin w_cls = CLS_STORE; store = c_st_sw; end
            c_op_sh:                begin w_cls = CLS_STORE; store = c_st_sh; end
            c_op_sb:                begin w_cls = CLS_STORE; store = c_st_sb; end
            default:                w_cls = CLS_RI;
        endcase
    end

    // Class -> routing and hazard timing; defaults are the nop values
    always_comb begin
        npc_sel  = c_npc_pc4;
        srcb_imm = 1'b0;
        wsel     = c_wsel_alu;
        waddr    = 5'd0;
        load     = 1'b0;
        tuse_rs  = c_tuse_none;
        tuse_rt  = c_tuse_none;
        tnew     = c_tnew_none;
        ri       = 1'b0;
        case (w_cls)
            CLS_RALU:  begin waddr = w_rd; tuse_rs = c_tuse_e; tuse_rt = c_tuse_e; tnew = c_tnew_alu; end
            CLS_SHAMT: begin waddr = w_rd; tuse_rt = c_tuse_e; tnew = c_tnew_alu; end
            CLS_IALU:  begin waddr = w_rt; srcb_imm = 1'b1; tuse_rs = c_tuse_e; tnew = c_tnew_alu; end
            CLS_LUI:   begin waddr = w_rt; srcb_imm = 1'b1; tnew = c_tnew_alu; end
            CLS_LOAD:  begin
                waddr = w_rt; srcb_imm = 1'b1; load = 1'b1; wsel = c_wsel_mem;
                tuse_rs = c_tuse_e; tnew = c_tnew_mem;
            end
            CLS_STORE: begin srcb_imm = 1'b1; tuse_rs = c_tuse_e; tuse_rt = c_tuse_m; end
            CLS_BR2:   begin npc_sel = c_npc_br; tuse_rs = c_tuse_d; tuse_rt = c_tuse_d; end
            CLS_BR1:   begin npc_sel = c_npc_br; tuse_rs = c_tuse_d; end
            CLS_J:     npc_sel = c_npc_j;
            CLS_JAL:   begin npc_sel = c_npc_j; waddr = 5'd31; wsel = c_wsel_pc8; tnew = c_tnew_pc8; end
            CLS_JR:    begin npc_sel = c_npc_jr; tuse_rs = c_tuse_d; end
            CLS_JALR:  begin
                npc_sel = c_npc_jr; waddr = w_rd; wsel = c_wsel_pc8;
                tuse_rs = c_tuse_d; tnew = c_tnew_pc8;
            end
            CLS_MD:    begin tuse_rs = c_tuse_e; tuse_rt = c_tuse_e; end
            CLS_MF:    begin waddr = w_rd; wsel = c_wsel_mdu; tnew = c_tnew_alu; end
            CLS_MT:    tuse_rs = c_tuse_e;
            default:   ri = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_ctrl_unit
//  Description : Self-checking bench for decode_ctrl_unit: directed cases
//                followed by randomized instructions/operands/control, all
//                compared against a behavioural decode model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_unit;
    import decode_pkg::*;

`ifdef DECODE_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0, en = 1'b0, clr = 1'b0;
    logic [31:0] instr_in = 32'd0, rs_val = 32'd0, rt_val = 32'd0;
    logic [31:0] instr, ext_out;
    logic        is_br, srcb_imm, load, ri;
    logic [1:0]  npc_sel, wsel, store, tuse_rs, tuse_rt, tnew;
    logic [4:0]  alu_op, waddr;
    logic [2:0]  ld_type;
    logic [3:0]  mdu_op;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_instr = 32'd0;

    decode_ctrl_unit #(.RESET_INSTR(32'h0000_0000)) dut (
        .clk(clk), .resetn(resetn), .en(en), .clr(clr), .instr_in(instr_in),
        .rs_val(rs_val), .rt_val(rt_val), .instr(instr), .ext_out(ext_out),
        .is_br(is_br), .npc_sel(npc_sel), .alu_op(alu_op), .srcb_imm(srcb_imm),
        .wsel(wsel), .waddr(waddr), .load(load), .store(store), .ld_type(ld_type),
        .mdu_op(mdu_op), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew(tnew), .ri(ri)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ext;
        logic        br;
        logic [1:0]  npc;
        logic [4:0]  alu;
        logic        srcb;
        logic [1:0]  wsel;
        logic [4:0]  waddr;
        logic        load;
        logic [1:0]  store;
        logic [2:0]  ld;
        logic [3:0]  mdu;
        logic [1:0]  trs, trt, tnew;
        logic        ri;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, m_instr);
        end
    endtask

    // Behavioural decode: property sets over opcode/funct, derived field by field
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        logic [4:0] rt = ins[20:16];
        logic [4:0] rd = ins[15:11];
        logic [15:0] imm = ins[15:0];
        bit rt0 = (op == 6'h00);
        bit r_alu = rt0 && (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07});
        bit r_sh  = rt0 && (fn inside {6'h00, 6'h02, 6'h03});
        bit jr    = rt0 && fn == 6'h08;
        bit jalr  = rt0 && fn == 6'h09;
        bit md    = MDU_ON && rt0 && (fn inside {[6'h18:6'h1B]});
        bit mf    = MDU_ON && rt0 && (fn inside {6'h10, 6'h12});
        bit mt    = MDU_ON && rt0 && (fn inside {6'h11, 6'h13});
        bit ialu  = op inside {[6'h08:6'h0F]};
        bit lui   = op == 6'h0F;
        bit ld    = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        bit st    = op inside {6'h28, 6'h29, 6'h2B};
        bit br2   = op inside {6'h04, 6'h05};
        bit br1   = (op inside {6'h06, 6'h07}) || (op == 6'h01 && rt <= 5'd1);
        bit j     = op == 6'h02;
        bit jal   = op == 6'h03;
        bit known = r_alu || r_sh || jr || jalr || md || mf || mt || ialu || ld || st ||
                    br2 || br1 || j || jal;
        int sa = $signed(a);

        if (op inside {6'h0C, 6'h0D, 6'h0E}) e.ext = {16'd0, imm};
        else if (lui)                        e.ext = {imm, 16'd0};
        else                                 e.ext = 32'($signed(imm));

        e.br = 1'b0;
        if (op == 6'h04) e.br = (a == b);
        if (op == 6'h05) e.br = (a != b);
        if (op == 6'h06) e.br = (sa <= 0);
        if (op == 6'h07) e.br = (sa > 0);
        if (op == 6'h01 && rt == 5'd0) e.br = (sa < 0);
        if (op == 6'h01 && rt == 5'd1) e.br = (sa >= 0);

        e.npc = 0; e.alu = c_alu_add; e.srcb = 0; e.wsel = 0; e.waddr = 0; e.load = 0;
        e.store = 0; e.ld = 0; e.mdu = 0; e.trs = 3; e.trt = 3; e.tnew = 0; e.ri = !known;
        if (!known) return e;

        e.npc  = (br1 || br2) ? 2'd1 : (j || jal) ? 2'd2 : (jr || jalr) ? 2'd3 : 2'd0;
        e.waddr = (r_alu || r_sh || jalr || mf) ? rd : (ialu || ld) ? rt : jal ? 5'd31 : 5'd0;
        e.wsel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : mf ? 2'd3 : 2'd0;
        e.load = ld;
        e.srcb = ialu || ld || st;
        e.store = (op == 6'h2B) ? 2'd1 : (op == 6'h29) ? 2'd2 : (op == 6'h28) ? 2'd3 : 2'd0;
        case (op)
            6'h21: e.ld = 1; 6'h25: e.ld = 2; 6'h20: e.ld = 3; 6'h24: e.ld = 4;
            default: e.ld = 0;
        endcase
        if (md || mf || mt) begin
            case (fn)
                6'h18: e.mdu = 1; 6'h19: e.mdu = 2; 6'h1A: e.mdu = 3; 6'h1B: e.mdu = 4;
                6'h10: e.mdu = 5; 6'h12: e.mdu = 6; 6'h11: e.mdu = 7; default: e.mdu = 8;
            endcase
        end
        e.trs  = (br1 || br2 || jr || jalr) ? 2'd0 :
                 (r_alu || (ialu && !lui) || ld || st || md || mt) ? 2'd1 : 2'd3;
        e.trt  = br2 ? 2'd0 : st ? 2'd2 : (r_alu || r_sh || md) ? 2'd1 : 2'd3;
        e.tnew = ld ? 2'd3 : (jal || jalr) ? 2'd1 : (r_alu || r_sh || ialu || mf) ? 2'd2 : 2'd0;
        if (r_alu || r_sh) begin
            case (fn)
                6'h22, 6'h23: e.alu = c_alu_sub;  6'h24: e.alu = c_alu_and;
                6'h25: e.alu = c_alu_or;          6'h26: e.alu = c_alu_xor;
                6'h27: e.alu = c_alu_nor;         6'h2A: e.alu = c_alu_slt;
                6'h2B: e.alu = c_alu_sltu;        6'h00: e.alu = c_alu_sll;
                6'h02: e.alu = c_alu_srl;         6'h03: e.alu = c_alu_sra;
                6'h04: e.alu = c_alu_sllv;        6'h06: e.alu = c_alu_srlv;
                6'h07: e.alu = c_alu_srav;        default: e.alu = c_alu_add;
            endcase
        end else if (ialu) begin
            case (op)
                6'h0A: e.alu = c_alu_slt; 6'h0B: e.alu = c_alu_sltu; 6'h0C: e.alu = c_alu_and;
                6'h0D: e.alu = c_alu_or;  6'h0E: e.alu = c_alu_xor;  6'h0F: e.alu = c_alu_lui;
                default: e.alu = c_alu_add;
            endcase
        end
        return e;
    endfunction

    task automatic check_all();
        exp_t e = model(m_instr, rs_val, rt_val);
        chk("instr", instr, m_instr);
        chk("ext_out", ext_out, e.ext);
        chk("is_br", 32'(is_br), 32'(e.br));
        chk("npc_sel", 32'(npc_sel), 32'(e.npc));
        chk("alu_op", 32'(alu_op), 32'(e.alu));
        chk("srcb_imm", 32'(srcb_imm), 32'(e.srcb));
        chk("wsel", 32'(wsel), 32'(e.wsel));
        chk("waddr", 32'(waddr), 32'(e.waddr));
        chk("load", 32'(load), 32'(e.load));
        chk("store", 32'(store), 32'(e.store));
        chk("ld_type", 32'(ld_type), 32'(e.ld));
        chk("mdu_op", 32'(mdu_op), 32'(e.mdu));
        chk("tuse_rs", 32'(tuse_rs), 32'(e.trs));
        chk("tuse_rt", 32'(tuse_rt), 32'(e.trt));
        chk("tnew", 32'(tnew), 32'(e.tnew));
        chk("ri", 32'(ri), 32'(e.ri));
    endtask

    task automatic step(input logic rn, input logic e, input logic c,
                        input logic [31:0] ii, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        resetn = rn; en = e; clr = c; instr_in = ii; rs_val = a; rt_val = b;
        @(posedge clk);
        if (!rn || c)  m_instr = 32'h0000_0000;
        else if (e)    m_instr = ii;
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [24] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                                 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
        logic [5:0] fns [28] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h28, 6'h29};
        logic [31:0] ins = $urandom;
        if ($urandom_range(0, 9) == 0) return ins;
        ins[31:26] = ops[$urandom_range(0, 23)];
        if ($urandom_range(0, 7) == 0) ins[31:26] = ($urandom_range(0, 1) != 0) ? 6'h28 : 6'h29;
        if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 27)];
        if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 2));
        return ins;
    endfunction

    function automatic logic [31:0] rand_val(input logic [31:0] other);
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return other;
            3: return 32'hFFFF_FFFF;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        // Reset with a load presented: reset must win
        step(1'b0, 1'b1, 1'b0, 32'h8C22_0004, 32'd0, 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_ri", 32'(ri), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h3C01_1234, 32'd0, 32'd0);
        chk("lui_ext", ext_out, 32'h1234_0000);
        chk("lui_waddr", 32'(waddr), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h8C22_0004, 32'd0, 32'd0);
        chk("lw_tnew", 32'(tnew), 32'd3);
        chk("lw_ext", ext_out, 32'd4);
        step(1'b1, 1'b1, 1'b0, 32'h1022_FFFF, 32'd5, 32'd5);
        chk("beq_taken", 32'(is_br), 32'd1);
        chk("beq_ext", ext_out, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'd5, 32'd6);
        chk("beq_not_taken", 32'(is_br), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0420_0003, 32'h8000_0000, 32'd0);
        chk("bltz_taken", 32'(is_br), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0421_0003, 32'd0, 32'd0);
        chk("bgez_zero", 32'(is_br), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0C00_0010, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h2001_0001, 32'd0, 32'd0);
        chk("jal_hold", instr, 32'h0C00_0010);
        chk("jal_waddr", 32'(waddr), 32'd31);
        chk("jal_npc", 32'(npc_sel), 32'd2);
        step(1'b1, 1'b1, 1'b1, 32'h2001_0001, 32'd0, 32'd0);
        chk("clr_instr", instr, 32'd0);
        // MDU group: decoded or reserved depending on the build
        step(1'b1, 1'b1, 1'b0, 32'h0022_0018, 32'd0, 32'd0);
        chk("mult_ri", 32'(ri), MDU_ON ? 32'd0 : 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0000_1812, 32'd0, 32'd0);
        chk("mflo_waddr", 32'(waddr), MDU_ON ? 32'd3 : 32'd0);
        // Unknown opcode
        step(1'b1, 1'b1, 1'b0, 32'hFC00_0000, 32'd0, 32'd0);
        chk("unknown_ri", 32'(ri), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            a = rand_val($urandom);
            b = rand_val(a);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), rand_instr(), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_unit.md
Name: decode_ctrl_unit

Overview:
- Decode-stage block of the 5-stage MIPS core: a decode instruction register, the main decoder, the immediate extender and the branch comparator.
- Latches the fetched instruction and decodes it into control and hazard-timing fields.
- Extends the 16-bit immediate and evaluates the branch condition on forwarded operands.
- Feeds the NPC unit, the hazard unit and the E-stage pipeline register.

Parameters:
- RESET_INSTR, 32'h0000_0000, instruction value loaded on reset or clear (sll $0,$0,0 = nop).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- en  in  1  instruction-register load enable (low = hold/stall)
- clr  in  1  synchronous flush of the instruction register
- instr_in  in  32  fetched instruction
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- instr  out  32  latched instruction
- ext_out  out  32  extended immediate
- is_br  out  1  branch condition true
- npc_sel  out  2  0=pc+4, 1=branch, 2=j/jal, 3=jr/jalr
- alu_op  out  5  ALU operation code (encoding in shared package)
- srcb_imm  out  1  ALU B operand = ext_out
- wsel  out  2  result source: 0=alu, 1=mem, 2=pc+8, 3=mdu
- waddr  out  5  destination register, 0 = none
- load  out  1  instruction is a load
- store  out  2  0=none, 1=sw, 2=sh, 3=sb
- ld_type  out  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu
- mdu_op  out  4  MDU operation, 0 = none
- tuse_rs  out  2  stage-distance until rs is needed
- tuse_rt  out  2  stage-distance until rt is needed
- tnew  out  2  D-stage distance until the result is produced
- ri  out  1  reserved/unknown instruction

Behaviour:
- Instruction register:
  - On rising clk: resetn=0 or clr=1 loads RESET_INSTR (reset wins).
  - Otherwise en=1 loads instr_in; en=0 holds.
  - clr overrides en.
- All other outputs are purely combinational from the register and rs_val/rt_val; there is no other state.
- Decoded set: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, lh, lhu, lb, lbu, sw, sh, sb, beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr, plus the MDU group (see Optional Feature).
- Extender:
  - andi/ori/xori use zero-extension.
  - lui places the immediate in bits 31:16 with zeros in bits 15:0.
  - All other instructions sign-extend.
- Comparator, signed 32-bit:
  - beq: rs==rt. bne: rs!=rt.
  - blez: rs<=0. bgtz: rs>0.
  - bltz: rs<0 (regimm rt=0). bgez: rs>=0 (regimm rt=1).
  - is_br=0 for every non-branch instruction.
- npc_sel:
  - 1 only for branches, independent of is_br (the NPC unit gates the branch with is_br).
  - 2 for j and jal; 3 for jr and jalr; 0 otherwise.
- Destination register (waddr):
  - R-type arithmetic/logic/shift, jalr and mfhi/mflo write rd.
  - I-type ALU ops and loads write rt.
  - jal writes 31.
  - Stores, branches, j, jr, mult/div/mt write 0.
- wsel: loads=1; jal/jalr=2; mfhi/mflo=3; everything else 0.
- tuse (unused operand = 3, which never stalls):
  - Branches, jr, jalr: rs=0; beq/bne also rt=0.
  - ALU and MDU operands: 1.
  - Load/store base: rs=1. Store data: rt=2.
- tnew: ALU and mf=2; load=3; jal/jalr=1; no destination=0.
- Unknown opcode or funct:
  - ri=1 and all outputs take their nop values: waddr=0, npc_sel=0, store=0, load=0.
  - ri=0 for every listed instruction.

Optional Feature:
- Macro DECODE_MDU_EN.
- Defined:
  - mult, multu, div, divu, mfhi, mflo, mthi, mtlo are decoded.
  - mdu_op is nonzero for these, with codes 1..8 in that order.
  - mf ops write rd with wsel=3 and tnew=2.
- Undefined: the MDU group decodes as unknown (ri=1), and mdu_op is tied to 0.

Decomposition:
- Package decode_pkg holds:
  - Opcode and funct constants.
  - alu_op, npc_sel, wsel, store, ld_type and mdu_op encodings.
  - Tuse/Tnew constants.
- Natural sub-module: branch_cmp (the comparator plus its condition decode).
- Extender and decoder remain inline.

Test Plan:
- resetn=0 for one clk with en=1 and instr_in=0x8C220004 -> instr=0; waddr=0, ri=0, npc_sel=0.
- Load 0x3C011234 (lui $1,0x1234) -> ext_out=0x12340000, waddr=1, srcb_imm=1, tnew=2.
- Load 0x8C220004 (lw $2,4($1)) -> load=1, waddr=2, wsel=1, tnew=3, tuse_rs=1, ext_out=4.
- Load 0x1022FFFF (beq $1,$2,-1):
  - rs_val=rt_val=5 -> is_br=1, npc_sel=1, ext_out=0xFFFFFFFF, tuse_rs=tuse_rt=0.
  - rt_val=6 -> is_br=0.
- Load bltz ($1) with rs_val=0x80000000 -> is_br=1; then load bgez ($1) with rs_val=0 -> is_br=1.
- Load 0x0C000010 (jal), then en=0 with new instr_in -> waddr=31, wsel=2, npc_sel=2; instr holds. Then assert clr -> instr=0.
